addend_recover: RTL and testbench

- Inverse companion of the team's 12-bit parallel-prefix adder. Given a 13-bit sum S and one 12-bit addend A, it recovers the other addend B = S - A.
- Arithmetic is digit-serial, DIGIT bits per cycle, with a borrow register. A valid/ready handshake applies on both sides.
- Output is also packed in the adder's interleaved operand format, so the pair can be replayed into the adder for self-check in the test harness.

---
 rtl/addend_recover.sv | 161 ++++++++++++++++
 tb/tb_addend_recover.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/addend_recover.sv
// addend_recover: recovers B = S - A digit-serially (DIGIT bits/cycle), packs {B,A} interleaved; macro ADDEND_RECOVER_SKID_EN.
// Latency: out_valid rises NDIG edges after the accepting edge; all outputs registered or decoded from state.
// Backpressure: result held stable until out_ready; with ADDEND_RECOVER_SKID_EN one request may queue during HOLD.
module addend_recover #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:0]     sum_i,
  input  logic [WIDTH-1:0]   addend_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   diff_o,
  output logic [2*WIDTH-1:0] pair_o,
  output logic               range_err
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("addend_recover: DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               borrow_q;
  logic               s_top_q;
  logic [WIDTH-1:0]   s_q, a_q, b_q;
  logic [WIDTH-1:0]   diff_q;
  logic [2*WIDTH-1:0] pair_q;
  logic               err_q;

  logic               accept, out_fire, last_dig, restart, load, pend_free;
  logic [WIDTH:0]     ld_sum;
  logic [WIDTH-1:0]   ld_add;
  logic [DIGIT:0]     dig;
  logic [WIDTH-1:0]   a_nxt, b_nxt;
  logic [2*WIDTH-1:0] pair_nxt;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_dig = (state_q == CALC) && (cnt_q == LAST);
  assign load     = ((state_q == IDLE) && accept) || ((state_q == HOLD) && restart);

`ifdef ADDEND_RECOVER_SKID_EN
  logic             pend_q;
  logic [WIDTH:0]   pend_sum_q;
  logic [WIDTH-1:0] pend_add_q;

  // A request arriving together with the output handshake bypasses the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_sum_q <= '0;
      pend_add_q <= '0;
    end else if (state_q == HOLD) begin
      if (out_fire) begin
        pend_q <= 1'b0;
      end else if (accept) begin
        pend_q     <= 1'b1;
        pend_sum_q <= sum_i;
        pend_add_q <= addend_i;
      end
    end
  end

  assign pend_free = ~pend_q;
  assign restart   = out_fire & (pend_q | accept);
  assign ld_sum    = pend_q ? pend_sum_q : sum_i;
  assign ld_add    = pend_q ? pend_add_q : addend_i;
`else
  assign pend_free = 1'b0;
  assign restart   = 1'b0;
  assign ld_sum    = sum_i;
  assign ld_add    = addend_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_dig) state_d = HOLD;
      HOLD:    if (out_fire) state_d = restart ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = pend_free;
      end
      default: ;
    endcase
  end

  // Operands shift right one digit per cycle; A rotates so it is whole again after NDIG steps.
  always_comb begin
    dig      = {1'b0, s_q[DIGIT-1:0]} - {1'b0, a_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    b_nxt    = (b_q >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));
    a_nxt    = (a_q >> DIGIT) | (a_q << (WIDTH - DIGIT));
    pair_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pair_nxt[2*i]   = a_nxt[i];
      pair_nxt[2*i+1] = b_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      s_top_q  <= 1'b0;
      s_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      pair_q   <= '0;
      err_q    <= 1'b0;
    end else if (load) begin
      s_q      <= ld_sum[WIDTH-1:0];
      s_top_q  <= ld_sum[WIDTH];
      a_q      <= ld_add;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == CALC) begin
      s_q      <= s_q >> DIGIT;
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      borrow_q <= dig[DIGIT];
      cnt_q    <= cnt_q + 1'b1;
      if (last_dig) begin
        diff_q <= b_nxt;
        pair_q <= pair_nxt;
        // Sum MSB cancels the borrow only when the true difference fits in WIDTH bits.
        err_q  <= s_top_q ^ dig[DIGIT];
      end
    end
  end

  assign diff_o    = diff_q;
  assign pair_o    = pair_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_addend_recover.sv
// Bench for addend_recover: directed table, latency/stall/reset sequences and a randomized model check.
module tb_addend_recover;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] sum_i = '0;
  logic [11:0] addend_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] diff_o;
  logic [23:0] pair_o;
  logic        range_err;

  int n_vec = 0;
  int n_err = 0;

  addend_recover dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_i(sum_i), .addend_i(addend_i), .out_valid(out_valid), .out_ready(out_ready),
    .diff_o(diff_o), .pair_o(pair_o), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] s;
    logic [11:0] a;
    logic [11:0] d;
    logic        e;
    logic [23:0] p;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] interleave(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] p;
    p = '0;
    for (int i = 0; i < 12; i++) begin
      p[2*i]   = a[i];
      p[2*i+1] = b[i];
    end
    return p;
  endfunction

  // Plain integer subtraction: the true difference decides both the wrapped value and the range flag.
  task automatic model(input logic [12:0] s, input logic [11:0] a,
                       output logic [11:0] d, output logic e, output logic [23:0] p);
    int diff;
    diff = int'(s) - int'(a);
    d = 12'(diff & 4095);
    e = (diff < 0) || (diff > 4095);
    p = interleave(a, d);
  endtask

  // Called and returns #1 after a rising edge.
  task automatic send(input logic [12:0] s, input logic [11:0] a);
    int t;
    t = 0;
    sum_i = s;
    addend_i = a;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sum_i = 13'($urandom);
    addend_i = 12'($urandom);
  endtask

  task automatic recv(input string name, input logic [11:0] ed, input logic ee,
                      input logic [23:0] ep, input int stall);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      repeat (stall) begin @(posedge clk); #1; end
      chk({name, "_diff"}, 32'(diff_o), 32'(ed));
      chk({name, "_err"}, 32'(range_err), 32'(ee));
      chk({name, "_pair"}, 32'(pair_o), 32'(ep));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] ed, ed2;
    logic        ee, ee2;
    logic [23:0] ep, ep2;
    int          lat;
    logic [12:0] rs;
    logic [11:0] ra;

    tbl[0] = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0, 24'hFFFFFF};
    tbl[1] = '{13'd100, 12'd37, 12'h03F, 1'b0, 24'h000EBB};
    tbl[2] = '{13'd5, 12'd9, 12'hFFC, 1'b1, interleave(12'd9, 12'hFFC)};
    tbl[3] = '{13'h1000, 12'h000, 12'h000, 1'b1, 24'h000000};
    tbl[4] = '{13'h1FFF, 12'h000, 12'hFFF, 1'b1, interleave(12'h000, 12'hFFF)};
    tbl[5] = '{13'h0FFF, 12'hFFF, 12'h000, 1'b0, interleave(12'hFFF, 12'h000)};
    tbl[6] = '{13'h0000, 12'h001, 12'hFFF, 1'b1, interleave(12'h001, 12'hFFF)};
    tbl[7] = '{13'h1000, 12'h001, 12'hFFF, 1'b0, interleave(12'h001, 12'hFFF)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", 32'(diff_o), 32'd0);
    chk("rst_pair", 32'(pair_o), 32'd0);
    chk("rst_err", 32'(range_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First-result latency
    sum_i = 13'h1FFE;
    addend_i = 12'hFFF;
    in_valid = 1'b1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    chk("calc_out_valid", 32'(out_valid), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd6);
    recv("lat_vec", 12'hFFF, 1'b0, 24'hFFFFFF, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].s, tbl[i].a);
      recv($sformatf("tbl%0d", i), tbl[i].d, tbl[i].e, tbl[i].p, 0);
    end

    // Result held with out_ready low for 10 cycles
    send(13'd100, 12'd37);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sum_i = 13'h0ABC;
    addend_i = 12'h123;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic took;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_diff", 32'(diff_o), 32'h03F);
      chk("hold_pair", 32'(pair_o), 32'h000EBB);
`ifdef ADDEND_RECOVER_SKID_EN
      chk("hold_in_ready", 32'(in_ready), (i == 0) ? 32'd1 : 32'd0);
`else
      chk("hold_in_ready", 32'(in_ready), 32'd0);
`endif
      took = in_valid & in_ready;
      @(posedge clk); #1;
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    recv("hold_res1", 12'h03F, 1'b0, 24'h000EBB, 0);
`ifdef ADDEND_RECOVER_SKID_EN
    model(13'h0ABC, 12'h123, ed2, ee2, ep2);
    recv("hold_res2", ed2, ee2, ep2, 0);
`endif

    // Reset pulse at the third CALC edge
    send(13'h1FFE, 12'h001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_diff", 32'(diff_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) lat++;
      @(posedge clk); #1;
    end
    chk("abort_no_result", 32'(lat), 32'd0);
    send(13'd20, 12'd7);
    recv("after_abort", 12'd13, 1'b0, interleave(12'd7, 12'd13), 0);

    // Randomized against the integer model
    for (int i = 0; i < 150; i++) begin
      ra = 12'($urandom_range(0, 4095));
      case (i % 5)
        0: rs = 13'(int'(ra) + 4096);
        1: rs = {1'b0, ra};
        default: rs = 13'($urandom_range(0, 8191));
      endcase
      model(rs, ra, ed, ee, ep);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(rs, ra);
      recv($sformatf("rnd%0d", i), ed, ee, ep, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
